// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache geometry, frame layout and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = $clog2(ICACHE_SETS);
  localparam int ITAG_W      = 30 - IIDX_W;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct_frame_array.sv
// Frame storage for the direct-mapped icache: async-clearable valid bits,
// one combinational read port, one synchronous write port and a flush-all input.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        flush,
  input  logic                        we,
  input  logic [$clog2(SETS)-1:0]     ridx,
  input  logic [$clog2(SETS)-1:0]     widx,
  input  logic [29-$clog2(SETS):0]    wtag,
  input  word_t                       wdata,
  output logic                        rvalid,
  output logic [29-$clog2(SETS):0]    rtag,
  output word_t                       rdata
);

  localparam int TAG_W = 30 - $clog2(SETS);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS];

  // flush wins over a same-cycle write so a discarded fill never becomes visible
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      valid <= '0;
    else if (flush)
      valid <= '0;
    else if (we)
      valid[widx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (we && !flush) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-block instruction cache with single-word miss fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//   state | meaning
//   IDLE  | serve fetches combinationally; a miss captures its address
//   FETCH | iREN held with iaddr=miss_addr until iwait drops, then fill
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state;
  word_t            miss_addr;
  logic             iren_q;
  logic             hit;
  logic             miss_start;
  logic             fill;
  logic             f_valid;
  logic [TAG_W-1:0] f_tag;
  word_t            f_data;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^imemaddr[1:0];

  icache_frame_array #(.SETS(SETS)) u_frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .we    (fill),
    .ridx  (imemaddr[IDX_W+1:2]),
    .widx  (miss_addr[IDX_W+1:2]),
    .wtag  (miss_addr[31:IDX_W+2]),
    .wdata (iload),
    .rvalid(f_valid),
    .rtag  (f_tag),
    .rdata (f_data)
  );

  assign hit        = (state == IDLE) && imemREN && !flush && f_valid
                      && (f_tag == imemaddr[31:IDX_W+2]);
  assign miss_start = (state == IDLE) && imemREN && !hit && !flush;
  assign fill       = (state == FETCH) && !iwait && !flush;

  assign ihit     = hit;
  assign imemload = hit ? f_data : '0;
  assign iREN     = iren_q;
  assign iaddr    = miss_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      iren_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            state     <= FETCH;
            miss_addr <= {imemaddr[31:2], 2'b00};
            iren_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (flush || !iwait) begin
            state  <= IDLE;
            iren_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          iren_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (miss_start && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
